// File: rtl/dsp_mul_pkg.sv
// Shared types and helpers for the DSP multiplier operand loader.
package dsp_mul_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    ISSUE  = 2'd2
  } state_e;

  function automatic int unsigned ceil_bytes(input int unsigned bits);
    return (bits + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/dsp_mul_operand_loader.sv
// Assembles A/B multiplier operands from an MSB-first byte stream and issues
// each completed pair over a valid/ready handshake, with frame-length checking.
module dsp_mul_operand_loader
  import dsp_mul_pkg::*;
#(
  parameter int unsigned A_BITS   = 64,
  parameter int unsigned B_BITS   = 64,
  parameter int unsigned CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cke,
  input  logic [7:0]          s_data,
  input  logic                s_last,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [A_BITS-1:0]   m_a,
  output logic [B_BITS-1:0]   m_b,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                err_len,
  output logic [CNT_BITS-1:0] pair_cnt
);

  localparam int unsigned A_BYTES   = ceil_bytes(A_BITS);
  localparam int unsigned B_BYTES   = ceil_bytes(B_BITS);
  localparam int unsigned MAX_BYTES = (A_BYTES > B_BYTES) ? A_BYTES : B_BYTES;
  localparam int unsigned BC_BITS   = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  state_e              state_q, state_d;
  logic [BC_BITS-1:0]  cnt_q, cnt_d;
  logic [A_BITS-1:0]   a_sr, a_d;
  logic [B_BITS-1:0]   b_sr, b_d;
  logic                m_valid_d;
  logic                err_d;
  logic [CNT_BITS-1:0] pair_cnt_d;
  logic                accept_c;
  logic                issue_c;

  // Ready depends only on state, cke and reset, never on m_ready.
  assign s_ready  = cke & reset_n & (state_q != ISSUE);
  assign accept_c = s_valid & s_ready & cke;
  assign issue_c  = m_valid & m_ready & cke;

  assign m_a = a_sr;
  assign m_b = b_sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= LOAD_A;
      cnt_q    <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      m_valid  <= 1'b0;
      err_len  <= 1'b0;
      pair_cnt <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr     <= a_d;
      b_sr     <= b_d;
      m_valid  <= m_valid_d;
      err_len  <= err_d;
      pair_cnt <= pair_cnt_d;
    end
  end

  // Next-state logic; with cke low every register holds its value.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_sr;
    b_d        = b_sr;
    m_valid_d  = m_valid;
    err_d      = cke ? 1'b0 : err_len;
    pair_cnt_d = pair_cnt;

    unique case (state_q)
      LOAD_A: begin
        if (accept_c) begin
          a_d = A_BITS'({a_sr, s_data});
          if (s_last) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = LOAD_A;
          end else if (cnt_q == BC_BITS'(A_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = LOAD_B;
          end else begin
            cnt_d = cnt_q + BC_BITS'(1);
          end
        end
      end
      LOAD_B: begin
        if (accept_c) begin
          b_d = B_BITS'({b_sr, s_data});
          if (cnt_q == BC_BITS'(B_BYTES - 1)) begin
            // Missing s_last on the final byte is flagged but the pair still issues.
            err_d     = ~s_last;
            m_valid_d = 1'b1;
            cnt_d     = '0;
            state_d   = ISSUE;
          end else if (s_last) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = LOAD_A;
          end else begin
            cnt_d = cnt_q + BC_BITS'(1);
          end
        end
      end
      ISSUE: begin
        if (issue_c) begin
          m_valid_d  = 1'b0;
          pair_cnt_d = pair_cnt + CNT_BITS'(1);
          state_d    = LOAD_A;
        end
      end
      default: begin
        state_d = LOAD_A;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_dsp_mul_operand_loader.sv
// Scoreboard bench for dsp_mul_operand_loader: default 64/64 instance plus a 12/20 instance.
module tb_dsp_mul_operand_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cke;
  logic [7:0]  s_data;
  logic        s_last, s_valid, s_ready;
  logic [63:0] m_a, m_b;
  logic        m_valid, m_ready, err_len;
  logic [31:0] pair_cnt;

  logic [7:0]  s2_data;
  logic        s2_last, s2_valid, s2_ready;
  logic [11:0] m2_a;
  logic [19:0] m2_b;
  logic        m2_valid, m2_ready, err2_len;
  logic [31:0] pair2_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned err_seen = 0;
  logic        cke_rand = 1'b0;
  logic [127:0] sb[$];

  always #5 clk = ~clk;

  dsp_mul_operand_loader u_dut (
    .clk(clk), .reset_n(reset_n), .cke(cke),
    .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
    .m_a(m_a), .m_b(m_b), .m_valid(m_valid), .m_ready(m_ready),
    .err_len(err_len), .pair_cnt(pair_cnt)
  );

  dsp_mul_operand_loader #(.A_BITS(12), .B_BITS(20), .CNT_BITS(32)) u_dut_small (
    .clk(clk), .reset_n(reset_n), .cke(cke),
    .s_data(s2_data), .s_last(s2_last), .s_valid(s2_valid), .s_ready(s2_ready),
    .m_a(m2_a), .m_b(m2_b), .m_valid(m2_valid), .m_ready(m2_ready),
    .err_len(err2_len), .pair_cnt(pair2_cnt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte and hold it until the DUT accepts it.
  task automatic send_byte(input logic [7:0] d, input logic l);
    logic acc;
    s_data = d; s_last = l; s_valid = 1'b1;
    for (int g = 0; g < 300; g++) begin
      @(negedge clk);
      acc = s_ready & cke;
      @(posedge clk); #1;
      if (acc) begin
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
    end
    check("accept_timeout", 128'd0, 128'd1);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] a, input logic [63:0] b);
    for (int i = 0; i < 8; i++) send_byte(a[63-8*i -: 8], 1'b0);
    for (int i = 0; i < 8; i++) send_byte(b[63-8*i -: 8], i == 7);
  endtask

  task automatic send_byte2(input logic [7:0] d, input logic l);
    logic acc;
    s2_data = d; s2_last = l; s2_valid = 1'b1;
    for (int g = 0; g < 300; g++) begin
      @(negedge clk);
      acc = s2_ready & cke;
      @(posedge clk); #1;
      if (acc) begin
        s2_valid = 1'b0; s2_last = 1'b0;
        return;
      end
    end
    check("accept2_timeout", 128'd0, 128'd1);
    s2_valid = 1'b0; s2_last = 1'b0;
  endtask

  task automatic wait_cnt(input int unsigned n);
    for (int g = 0; g < 300 && pair_cnt != n; g++) begin
      @(posedge clk); #1;
    end
    check("pair_cnt", 128'(pair_cnt), 128'(n));
  endtask

  // Pop the scoreboard on every consumed pair.
  initial begin
    logic [127:0] exp;
    forever begin
      @(negedge clk);
      if (m_valid && m_ready && cke) begin
        if (sb.size() == 0) check("unexpected_pair", 128'd1, 128'd0);
        else begin
          exp = sb.pop_front();
          check("m_a", 128'(m_a), 128'(exp[127:64]));
          check("m_b", 128'(m_b), 128'(exp[63:0]));
        end
      end
      if (err_len) err_seen++;
      if (cke_rand && !cke) check("s_ready_cke0", 128'(s_ready), 128'd0);
    end
  end

  initial begin
    cke = 1'b1;
    forever begin
      @(posedge clk); #1;
      cke = cke_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    s_data = '0; s_last = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    s2_data = '0; s2_last = 1'b0; s2_valid = 1'b0; m2_ready = 1'b0;
    #12;
    check("rst_s_ready", 128'(s_ready), 128'd0);
    check("rst_m_valid", 128'(m_valid), 128'd0);
    check("rst_m_a", 128'(m_a), 128'd0);
    check("rst_pair_cnt", 128'(pair_cnt), 128'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    check("post_rst_s_ready", 128'(s_ready), 128'd1);

    // 1: basic frame, m_valid one cycle after the last byte
    m_ready = 1'b1;
    sb.push_back({64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210});
    send_frame(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    check("t1_latency_m_valid", 128'(m_valid), 128'd1);
    check("t1_s_ready_issue", 128'(s_ready), 128'd0);
    wait_cnt(1);
    check("t1_err_seen", 128'(err_seen), 128'd0);

    // 2: back-pressure for 20 cycles
    m_ready = 1'b0;
    sb.push_back({64'hDEAD_BEEF_0BAD_F00D, 64'h1122_3344_5566_7788});
    send_frame(64'hDEAD_BEEF_0BAD_F00D, 64'h1122_3344_5566_7788);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t2_s_ready", 128'(s_ready), 128'd0);
      check("t2_m_valid", 128'(m_valid), 128'd1);
      check("t2_m_a", 128'(m_a), 128'(64'hDEAD_BEEF_0BAD_F00D));
      check("t2_m_b", 128'(m_b), 128'(64'h1122_3344_5566_7788));
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_cnt(2);
    check("t2_s_ready_after", 128'(s_ready), 128'd1);
    check("t2_m_valid_after", 128'(m_valid), 128'd0);

    // 3: early s_last in A
    for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i), i == 4);
    check("t3_err_pulse", 128'(err_len), 128'd1);
    @(posedge clk); #1;
    check("t3_err_clear", 128'(err_len), 128'd0);
    check("t3_no_valid", 128'(m_valid), 128'd0);
    check("t3_err_seen", 128'(err_seen), 128'd1);
    sb.push_back({64'hCAFE_0000_1234_5678, 64'h8765_4321_0000_FACE});
    send_frame(64'hCAFE_0000_1234_5678, 64'h8765_4321_0000_FACE);
    wait_cnt(3);

    // 4: non-byte-multiple widths
    send_byte2(8'hFA, 1'b0);
    send_byte2(8'hBC, 1'b0);
    send_byte2(8'hF1, 1'b0);
    send_byte2(8'h23, 1'b0);
    send_byte2(8'h45, 1'b1);
    check("t4_m_valid", 128'(m2_valid), 128'd1);
    check("t4_m_a", 128'(m2_a), 128'(12'hABC));
    check("t4_m_b", 128'(m2_b), 128'(20'h12345));
    check("t4_err", 128'(err2_len), 128'd0);
    m2_ready = 1'b1;
    @(posedge clk); #1;
    m2_ready = 1'b0;
    check("t4_pair_cnt", 128'(pair2_cnt), 128'd1);

    // 5: random clock-enable gaps
    cke_rand = 1'b1;
    sb.push_back({64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210});
    send_frame(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    cke_rand = 1'b0;
    wait_cnt(4);
    check("t5_err_seen", 128'(err_seen), 128'd1);

    // 6: reset mid-frame
    for (int i = 0; i < 9; i++) send_byte(8'(8'h10 + i), 1'b0);
    #3 reset_n = 1'b0;
    #1;
    check("t6_m_valid", 128'(m_valid), 128'd0);
    check("t6_m_a", 128'(m_a), 128'd0);
    check("t6_m_b", 128'(m_b), 128'd0);
    check("t6_pair_cnt", 128'(pair_cnt), 128'd0);
    check("t6_s_ready", 128'(s_ready), 128'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    sb.push_back({64'h5555_AAAA_3333_CCCC, 64'h0F0F_F0F0_1234_ABCD});
    send_frame(64'h5555_AAAA_3333_CCCC, 64'h0F0F_F0F0_1234_ABCD);
    wait_cnt(1);
    check("sb_empty", 128'(sb.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
